result_display: RTL and testbench

- Output-side counterpart of the switch-input capture block on the multicycle CPU board.
- Latches a 16-bit computation result from the CPU with a valid/ack handshake.
- Drives a 4-digit, time-multiplexed, active-low seven-segment display.
- When show_result is low, echoes the 4-bit switch input instead of the result.

---
 rtl/display_pkg.sv | 25 ++
 rtl/seg_decoder.sv | 17 +
 rtl/result_display.sv | 115 +++++++++++
 tb/tb_result_display.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : display_pkg
// Purpose  : Shared constants and types for the result display.
// Revision : 1.0
// ============================================================================
package display_pkg;

    typedef logic [1:0] digit_idx_t;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_DRIVE = 1'b1
    } phase_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Element [n] is the active-low {g,f,e,d,c,b,a} pattern for hex digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage
`default_nettype wire

// File: rtl/seg_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg_decoder
// Purpose  : Combinational hex nibble to active-low seven-segment pattern.
// Revision : 1.0
// ============================================================================
module seg_decoder
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = SEG_TABLE[nibble];

endmodule
`default_nettype wire

// File: rtl/result_display.sv
`default_nettype none
// ============================================================================
// Module   : result_display
// Purpose  : Captures CPU results via valid/ack and scans them onto a
//            4-digit multiplexed active-low seven-segment display.
// Revision : 1.0
// ============================================================================
module result_display
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2,
    parameter int LZ_BLANK     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] result_data,
    input  logic        result_valid,
    output logic        result_ack,
    input  logic        show_result,
    input  logic [3:0]  input_echo,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [3:0]  an_n
);

    localparam int                 c_cnt_w     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_slot_last = c_cnt_w'(REFRESH_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_blank_end = c_cnt_w'(BLANK_CYCLES);
    localparam phase_t             c_phase_rst = (BLANK_CYCLES > 0) ? PH_BLANK : PH_DRIVE;

    logic [c_cnt_w-1:0] slot_cnt_q,  slot_cnt_d;
    digit_idx_t         digit_idx_q, digit_idx_d;
    phase_t             phase_q,     phase_d;
    logic [15:0]        disp_reg_q,  disp_reg_d;
    logic               result_ack_q, result_ack_d;
    logic [6:0]         seg_n_q,     seg_n_d;
    logic               dp_n_q,      dp_n_d;
    logic [3:0]         an_n_q,      an_n_d;

    logic [3:0]         w_nibble;
    logic [6:0]         w_seg;
    logic               w_lz;

    seg_decoder u_seg_decoder (
        .nibble (w_nibble),
        .seg_n  (w_seg)
    );

    // A digit is a leading zero when it and every more-significant nibble are zero.
    always_comb begin
        w_lz = 1'b0;
        case (digit_idx_q)
            2'd1:    w_lz = (disp_reg_q[15:4]  == 12'h000);
            2'd2:    w_lz = (disp_reg_q[15:8]  == 8'h00);
            2'd3:    w_lz = (disp_reg_q[15:12] == 4'h0);
            default: w_lz = 1'b0;
        endcase
    end

    always_comb begin
        w_nibble     = show_result ? disp_reg_q[{digit_idx_q, 2'b00} +: 4] : input_echo;

        slot_cnt_d   = (slot_cnt_q == c_slot_last) ? '0 : slot_cnt_q + 1'b1;
        digit_idx_d  = (slot_cnt_q == c_slot_last) ? digit_idx_q + 2'd1 : digit_idx_q;
        phase_d      = (slot_cnt_d < c_blank_end) ? PH_BLANK : PH_DRIVE;

        disp_reg_d   = result_valid ? result_data : disp_reg_q;
        result_ack_d = result_valid;

        an_n_d       = 4'hF;
        seg_n_d      = SEG_BLANK;
        dp_n_d       = 1'b1;
        if (phase_q == PH_DRIVE) begin
            an_n_d = ~(4'b0001 << digit_idx_q);
            if (show_result) begin
                if (!((LZ_BLANK != 0) && w_lz)) begin
                    seg_n_d = w_seg;
                end
            end else if (digit_idx_q == 2'd0) begin
                seg_n_d = w_seg;
                dp_n_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q   <= '0;
            digit_idx_q  <= 2'd0;
            phase_q      <= c_phase_rst;
            disp_reg_q   <= 16'h0000;
            result_ack_q <= 1'b0;
            seg_n_q      <= SEG_BLANK;
            dp_n_q       <= 1'b1;
            an_n_q       <= 4'hF;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            digit_idx_q  <= digit_idx_d;
            phase_q      <= phase_d;
            disp_reg_q   <= disp_reg_d;
            result_ack_q <= result_ack_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
            an_n_q       <= an_n_d;
        end
    end

    assign result_ack = result_ack_q;
    assign seg_n      = seg_n_q;
    assign dp_n       = dp_n_q;
    assign an_n       = an_n_q;

endmodule
`default_nettype wire

// File: tb/tb_result_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_display
// Purpose  : Directed self-checking bench for result_display.
// Revision : 1.0
// ============================================================================
module tb_result_display;

    localparam int c_div   = 8;
    localparam int c_blank = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] result_data = 16'h0000;
    logic        result_valid = 1'b0;
    logic        result_ack;
    logic        show_result = 1'b1;
    logic [3:0]  input_echo = 4'h0;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;

    int n_checks = 0;
    int n_errors = 0;
    int k = 0;   // edges since last reset release

    result_display #(
        .REFRESH_DIV  (c_div),
        .BLANK_CYCLES (c_blank),
        .LZ_BLANK     (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .result_data  (result_data),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .show_result  (show_result),
        .input_echo   (input_echo),
        .seg_n        (seg_n),
        .dp_n         (dp_n),
        .an_n         (an_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    // One full scan (4 digits x c_div slots); e0..e3 are the expected drive patterns.
    task automatic scan_check(input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3,
                              input logic dp0);
        int         s;
        int         d;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        for (int i = 0; i < 4 * c_div; i++) begin
            tick();
            s = (k - 1) % c_div;
            d = ((k - 1) / c_div) % 4;
            if (s < c_blank) begin
                chk("an_blank",  16'(an_n),  16'hF);
                chk("seg_blank", 16'(seg_n), 16'h7F);
                chk("dp_blank",  16'(dp_n),  16'h1);
            end else begin
                exp_an = ~(4'b0001 << d);
                case (d)
                    0:       exp_seg = e0;
                    1:       exp_seg = e1;
                    2:       exp_seg = e2;
                    default: exp_seg = e3;
                endcase
                exp_dp = (d == 0) ? dp0 : 1'b1;
                chk("an_drive",  16'(an_n),  16'(exp_an));
                chk("seg_drive", 16'(seg_n), 16'(exp_seg));
                chk("dp_drive",  16'(dp_n),  16'(exp_dp));
            end
        end
    endtask

    task automatic capture(input logic [15:0] data);
        result_data  = data;
        result_valid = 1'b1;
        tick();
        chk("ack_capture", 16'(result_ack), 16'h1);
        result_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        // Reset held with toggling inputs
        for (int i = 0; i < 5; i++) begin
            result_valid = i[0];
            result_data  = 16'hA5A5 ^ 16'(i);
            show_result  = ~i[0];
            input_echo   = 4'(i);
            tick();
            chk("rst_seg", 16'(seg_n),      16'h7F);
            chk("rst_an",  16'(an_n),       16'hF);
            chk("rst_dp",  16'(dp_n),       16'h1);
            chk("rst_ack", 16'(result_ack), 16'h0);
        end
        result_valid = 1'b0;
        show_result  = 1'b1;
        input_echo   = 4'h0;

        // Release and capture 1234 on the very first edge
        rst_n = 1'b1;
        k     = 0;
        capture(16'h1234);
        chk("first_an", 16'(an_n), 16'hF);
        tick();
        chk("ack_drop", 16'(result_ack), 16'h0);
        k = 1;   // scan_check expects k to track edges; re-sync below
        k = 2;
        scan_check(7'h19, 7'h30, 7'h24, 7'h79, 1'b1);

        // Single pulse handshake
        chk("ack_idle", 16'(result_ack), 16'h0);
        capture(16'hBEEF);
        tick();
        chk("ack_pulse_end", 16'(result_ack), 16'h0);

        // Three-cycle burst
        result_valid = 1'b1;
        result_data  = 16'h0001;
        tick();
        chk("burst_ack1", 16'(result_ack), 16'h1);
        result_data  = 16'h0002;
        tick();
        chk("burst_ack2", 16'(result_ack), 16'h1);
        result_data  = 16'h0003;
        tick();
        chk("burst_ack3", 16'(result_ack), 16'h1);
        result_valid = 1'b0;
        tick();
        chk("burst_ack_end", 16'(result_ack), 16'h0);
        scan_check(7'h30, 7'h7F, 7'h7F, 7'h7F, 1'b1);

        // Leading-zero blanking
        capture(16'h00A0);
        scan_check(7'h40, 7'h08, 7'h7F, 7'h7F, 1'b1);
        capture(16'h0000);
        scan_check(7'h40, 7'h7F, 7'h7F, 7'h7F, 1'b1);

        // Echo mode
        show_result = 1'b0;
        input_echo  = 4'h7;
        scan_check(7'h78, 7'h7F, 7'h7F, 7'h7F, 1'b0);
        show_result = 1'b1;

        // Advance to two DRIVE cycles into digit 2, capture so an ack is pending
        begin
            int guard = 0;
            while ((((k - 1) % (4 * c_div)) != 2 * c_div + c_blank + 1) && guard < 64) begin
                tick();
                guard++;
            end
            if (guard >= 64) chk("sync_timeout", 16'h1, 16'h0);
        end
        capture(16'h5678);
        chk("pre_rst_an", 16'(an_n), 16'hB);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_seg", 16'(seg_n),      16'h7F);
        chk("async_an",  16'(an_n),       16'hF);
        chk("async_dp",  16'(dp_n),       16'h1);
        chk("async_ack", 16'(result_ack), 16'h0);
        tick();
        tick();
        rst_n = 1'b1;
        k     = 0;
        scan_check(7'h40, 7'h7F, 7'h7F, 7'h7F, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
